// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, state encoding and MEM/WB payload layout
package pipe_pkg;

  // Occupancy-coded states: the encoding doubles as the occ output
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // Core-wide constants
  localparam logic        RstEnable  = 1'b1;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'b00000;

  // Default MEM/WB payload packing, LSB first
  localparam int MEMWB_W          = 73;
  localparam int OFF_LLBIT_VALUE  = 0;
  localparam int OFF_LLBIT_WE     = 1;
  localparam int OFF_HILO         = 2;   // 32 bits of hi/lo data
  localparam int OFF_WHILO        = 34;
  localparam int OFF_WDATA        = 35;  // 32 bits
  localparam int OFF_WREG         = 67;
  localparam int OFF_WD           = 68;  // 5 bits

  // Write enables plus the destination register address; zeroing wd yields NOPRegAddr
  function automatic logic [MEMWB_W-1:0] build_memwb_mask();
    logic [MEMWB_W-1:0] m;
    m                 = '0;
    m[OFF_WD +: 5]    = ~NOPRegAddr;
    m[OFF_WREG]       = 1'b1;
    m[OFF_WHILO]      = 1'b1;
    m[OFF_LLBIT_WE]   = 1'b1;
    return m;
  endfunction

  localparam logic [MEMWB_W-1:0] WE_MASK_MEMWB = build_memwb_mask();

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter for performance monitors
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step on inc, stick at all-ones instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_wb_skid.sv
// rtl/mem_wb_skid.sv - elastic two-entry skid pipeline register with bubble masking
module mem_wb_skid
  import pipe_pkg::*;
#(
  parameter int                   PAYLOAD_W = 73,
  parameter logic [PAYLOAD_W-1:0] WE_MASK   = '0,
  parameter int                   CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [PAYLOAD_W-1:0] up_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [PAYLOAD_W-1:0] dn_data,
  output logic [1:0]           occ,
  output logic [CNT_W-1:0]     bubble_cnt
);

  pipe_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 up_ready_q, up_ready_d;
  logic                 dn_valid_q, dn_valid_d;
  logic [1:0]           occ_q, occ_d;

  logic up_fire;
  logic dn_fire;

  assign up_fire = up_valid & up_ready_q;
  assign dn_fire = dn_valid_q & dn_ready;

  // Next-state and storage update; handshake outputs are decoded from the next state
  // so they leave the block straight from flops
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (up_fire) begin
          state_d = ST_ONE;
          main_d  = up_data;
        end
      end
      ST_ONE: begin
        if (up_fire && dn_fire) begin
          main_d = up_data;
        end else if (up_fire) begin
          state_d = ST_TWO;
          skid_d  = up_data;
        end else if (dn_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (dn_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Any register contents left behind by a flush are stale and never presented as valid
    if (flush) begin
      state_d = ST_EMPTY;
    end

    up_ready_d = (state_d != ST_TWO);
    dn_valid_d = (state_d != ST_EMPTY);
    occ_d      = state_d;
  end

  // State, storage and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= up_ready_d;
      dn_valid_q <= dn_valid_d;
      occ_q      <= occ_d;
    end
  end

  // Bubble gating: an empty slot turns into a NOP by clearing write enables
  always_comb begin
    dn_data = dn_valid_q ? main_q : (main_q & ~WE_MASK);
  end

  assign up_ready = up_ready_q;
  assign dn_valid = dn_valid_q;
  assign occ      = occ_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (dn_ready & ~dn_valid_q),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_mem_wb_skid.sv
// tb/tb_mem_wb_skid.sv - scoreboard testbench for mem_wb_skid
module tb_mem_wb_skid;
  import pipe_pkg::*;

  localparam int W     = 73;
  localparam int CNT_W = 4;

  // All-ones payload with wd, wreg, whilo and LLbit_we cleared
  localparam logic [W-1:0] MASKED_ONES =
    {6'b000000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1};

  logic             clk;
  logic             rst;
  logic             flush;
  logic             up_valid;
  logic             up_ready;
  logic [W-1:0]     up_data;
  logic             dn_valid;
  logic             dn_ready;
  logic [W-1:0]     dn_data;
  logic [1:0]       occ;
  logic [CNT_W-1:0] bubble_cnt;

  logic [W-1:0] exp_q [$];
  int n_cmp;
  int n_bad;

  mem_wb_skid #(
    .PAYLOAD_W (W),
    .WE_MASK   (WE_MASK_MEMWB),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .dn_data    (dn_data),
    .occ        (occ),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every downstream transfer must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && dn_valid && dn_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got 0x%0h expected none at %0t", dn_data, $time);
      end else begin
        chk("dn_data_order", dn_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [W-1:0] ones;
    n_cmp    = 0;
    n_bad    = 0;
    ones     = '1;
    rst      = 1'b1;
    flush    = 1'b0;
    up_valid = 1'b0;
    up_data  = '0;
    dn_ready = 1'b0;
    #3;
    chk("rst_up_ready", W'(up_ready), W'(1));
    chk("rst_dn_valid", W'(dn_valid), W'(0));
    chk("rst_dn_data", dn_data, W'(0));
    chk("rst_occ", W'(occ), W'(0));
    chk("rst_bubble", W'(bubble_cnt), W'(0));
    step(2);
    rst = 1'b0;

    // Reset and fill
    up_valid = 1'b1; up_data = W'(1); exp_q.push_back(W'(1));
    step(1);
    up_data = W'(2); exp_q.push_back(W'(2));
    step(1);
    up_valid = 1'b0;
    chk("fill_occ", W'(occ), W'(2));
    chk("fill_up_ready", W'(up_ready), W'(0));
    chk("fill_dn_data", dn_data, W'(1));
    chk("fill_dn_valid", W'(dn_valid), W'(1));
    dn_ready = 1'b1;
    step(2);
    chk("drain_occ", W'(occ), W'(0));
    chk("drain_left", W'(exp_q.size()), W'(0));
    chk("drain_bubble", W'(bubble_cnt), W'(0));

    // Streaming
    up_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      up_data = W'(100 + i);
      exp_q.push_back(W'(100 + i));
      step(1);
    end
    chk("stream_inflight", W'(exp_q.size()), W'(1));
    chk("stream_occ", W'(occ), W'(1));
    up_valid = 1'b0;
    step(1);
    chk("stream_left", W'(exp_q.size()), W'(0));
    chk("stream_bubble", W'(bubble_cnt), W'(1));

    // Bubble masking with stale all-ones main
    up_valid = 1'b1; up_data = ones; exp_q.push_back(ones);
    step(1);
    up_valid = 1'b0;
    step(1);
    chk("mask_dn_valid", W'(dn_valid), W'(0));
    chk("mask_dn_data", dn_data, MASKED_ONES);
    chk("mask_bubble_a", W'(bubble_cnt), W'(2));
    step(2);
    chk("mask_bubble_b", W'(bubble_cnt), W'(4));
    chk("mask_dn_data_hold", dn_data, MASKED_ONES);

    // Flush in TWO with simultaneous dn_fire
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = W'('hA); exp_q.push_back(W'('hA));
    step(1);
    up_data = W'('hB);
    step(1);
    up_valid = 1'b0;
    chk("two_occ", W'(occ), W'(2));
    chk("two_main", dn_data, W'('hA));
    flush = 1'b1; dn_ready = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_occ", W'(occ), W'(0));
    chk("flush_up_ready", W'(up_ready), W'(1));
    chk("flush_dn_valid", W'(dn_valid), W'(0));
    chk("flush_bubble", W'(bubble_cnt), W'(4));
    step(2);
    chk("flush_left", W'(exp_q.size()), W'(0));
    chk("flush_bubble_b", W'(bubble_cnt), W'(6));

    // Counter saturation
    step(8);
    chk("sat_pre", W'(bubble_cnt), W'(14));
    step(12);
    chk("sat_hold", W'(bubble_cnt), W'(15));

    // Async reset while in TWO
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = W'(7);
    step(1);
    up_data = W'(8);
    step(1);
    up_valid = 1'b0;
    chk("pre_rst_occ", W'(occ), W'(2));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_up_ready", W'(up_ready), W'(1));
    chk("arst_dn_valid", W'(dn_valid), W'(0));
    chk("arst_dn_data", dn_data, W'(0));
    chk("arst_occ", W'(occ), W'(0));
    chk("arst_bubble", W'(bubble_cnt), W'(0));
    step(1);
    rst = 1'b0;
    dn_ready = 1'b1;
    up_valid = 1'b1; up_data = W'(5); exp_q.push_back(W'(5));
    step(1);
    up_valid = 1'b0;
    chk("post_rst_dn_valid", W'(dn_valid), W'(1));
    chk("post_rst_dn_data", dn_data, W'(5));
    step(1);
    chk("post_rst_left", W'(exp_q.size()), W'(0));
    chk("post_rst_bubble", W'(bubble_cnt), W'(1));

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
